vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator: divides the system clock into a pixel-rate tick and produces horizontal/vertical counters, sync pulses of configurable polarity, a blanking-aligned `video_on`, line/frame start strobes and a frame counter. It sits between the board clock and the pixel pipeline, with pixel generators, sprite/text renderers and frame-buffer readers. It replaces the fixed 640x480, hard-coded-divider timing block for all new display work.

---
 rtl/vga_timing_gen_pkg.sv | 41 ++++
 rtl/vga_tick_div.sv | 45 ++++
 rtl/vga_timing_gen.sv | 163 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_pkg
//   Shared timing definitions for the VGA raster generator and the pixel
//   pipeline that consumes its outputs:
//     - default 640x480@60 segment lengths (pixels / lines)
//     - an 800x600@60 segment set
//     - sync polarity encodings
//     - a helper that maps "sync is active" to the electrical level
// ---------------------------------------------------------------------------
package vga_timing_gen_pkg;

  // 640x480@60, 25.175 MHz nominal pixel clock
  localparam int VGA640_H_DISPLAY = 640;
  localparam int VGA640_H_FRONT   = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BACK    = 48;
  localparam int VGA640_V_DISPLAY = 480;
  localparam int VGA640_V_FRONT   = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BACK    = 33;

  // 800x600@60, 40 MHz nominal pixel clock (both syncs active-high)
  localparam int SVGA800_H_DISPLAY = 800;
  localparam int SVGA800_H_FRONT   = 40;
  localparam int SVGA800_H_SYNC    = 128;
  localparam int SVGA800_H_BACK    = 88;
  localparam int SVGA800_V_DISPLAY = 600;
  localparam int SVGA800_V_FRONT   = 1;
  localparam int SVGA800_V_SYNC    = 4;
  localparam int SVGA800_V_BACK    = 23;

  // Sync polarity: the level the sync line takes while the pulse is active
  localparam bit POL_ACTIVE_LOW  = 1'b0;
  localparam bit POL_ACTIVE_HIGH = 1'b1;

  // Electrical sync level for a given "inside the sync window" flag.
  function automatic logic sync_level(input logic active, input bit pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_tick_div.sv
// ---------------------------------------------------------------------------
// vga_tick_div
//   Modulo-CLK_DIV counter that turns the system clock into a one-cycle
//   pixel strobe. Also used standalone by the pixel pipeline.
//
//   Parameters
//     CLK_DIV   system clocks per pixel (>= 1; 1 = strobe on every clock)
//   Ports
//     i_clk     system clock, rising edge
//     i_reset   asynchronous active-low reset
//     i_en      count enable; when low the count holds and no strobe fires
//     o_p_tick  high for one clock in every CLK_DIV enabled clocks
// ---------------------------------------------------------------------------
module vga_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  output logic o_p_tick
);

  // A 1-bit counter is kept for CLK_DIV=1; it simply never leaves 0, so the
  // terminal-count compare is always true and the strobe follows i_en.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_div;
  logic          w_last;

  assign w_last = (r_div == DIV_LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_div <= '0;
    end else if (i_en) begin
      r_div <= w_last ? '0 : r_div + DW'(1);
    end
  end

  // Qualified by reset so no strobe is seen while the block is held in
  // reset, even in the CLK_DIV=1 case where the strobe is just i_en.
  assign o_p_tick = i_en && w_last && i_reset;

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA raster timing generator. A pixel strobe from
//   vga_tick_div advances a horizontal/vertical position; all decodes are
//   registered from the *next* position so they line up exactly with the
//   x/y presented in the same cycle.
//
//   Line order: active, front porch, sync, back porch (same for frames).
//
//   Parameters
//     CLK_DIV                               system clocks per pixel (>= 1)
//     H_DISPLAY/H_FRONT/H_SYNC/H_BACK       horizontal segments (pixels)
//     V_DISPLAY/V_FRONT/V_SYNC/V_BACK       vertical segments (lines)
//     H_POL, V_POL                          active sync level (0 = low)
//     CW                                    x/y width, 2^CW >= max totals
//   Ports
//     i_clk           system clock, rising edge
//     i_reset         asynchronous active-low reset
//     i_en            run enable; low holds every register, strobes go 0
//     o_p_tick        pixel strobe (one clock in CLK_DIV)
//     o_hsync/o_vsync registered syncs at H_POL/V_POL
//     o_video_on      registered, x < H_DISPLAY && y < V_DISPLAY
//     o_line_start    one-clock pulse after x becomes 0
//     o_frame_start   one-clock pulse after (x,y) becomes (0,0)
//     o_x, o_y        current position
//     o_frame_cnt     8-bit frame counter, steps with o_frame_start
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = VGA640_H_DISPLAY,
  parameter int H_FRONT   = VGA640_H_FRONT,
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BACK    = VGA640_H_BACK,
  parameter int V_DISPLAY = VGA640_V_DISPLAY,
  parameter int V_FRONT   = VGA640_V_FRONT,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BACK    = VGA640_V_BACK,
  parameter bit H_POL     = POL_ACTIVE_LOW,
  parameter bit V_POL     = POL_ACTIVE_LOW,
  parameter int CW        = 10
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_en,
  output logic          o_p_tick,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_video_on,
  output logic          o_line_start,
  output logic          o_frame_start,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic [7:0]    o_frame_cnt
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_DISP     = CW'(H_DISPLAY);
  localparam logic [CW-1:0] V_DISP     = CW'(V_DISPLAY);
  localparam logic [CW-1:0] HS_FIRST   = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] HS_LAST    = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST   = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] VS_LAST    = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // -------------------------------------------------------------------------
  // Pixel strobe
  // -------------------------------------------------------------------------
  logic w_p_tick;

  vga_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_en     (i_en),
    .o_p_tick (w_p_tick)
  );

  // -------------------------------------------------------------------------
  // Next position and its decodes
  // -------------------------------------------------------------------------
  logic          w_x_wrap;
  logic [CW-1:0] w_x_next;
  logic [CW-1:0] w_y_next;
  logic          w_hs_active_next;
  logic          w_vs_active_next;
  logic          w_video_next;
  logic          w_line_next;
  logic          w_frame_next;

  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_video_on;
  logic          r_line_start;
  logic          r_frame_start;
  logic [7:0]    r_frame_cnt;

  always_comb begin
    w_x_wrap = (r_x == H_LAST);
    w_x_next = w_x_wrap ? '0 : r_x + CW'(1);
    w_y_next = r_y;
    if (w_x_wrap) begin
      w_y_next = (r_y == V_LAST) ? '0 : r_y + CW'(1);
    end
    w_hs_active_next = (w_x_next >= HS_FIRST) && (w_x_next <= HS_LAST);
    w_vs_active_next = (w_y_next >= VS_FIRST) && (w_y_next <= VS_LAST);
    w_video_next     = (w_x_next < H_DISP) && (w_y_next < V_DISP);
    w_line_next      = (w_x_next == '0);
    w_frame_next     = w_line_next && (w_y_next == '0);
  end

  // -------------------------------------------------------------------------
  // Position and registered decodes
  // -------------------------------------------------------------------------
  // Reset parks the raster on the last pixel of the last line so that the
  // very first pixel strobe wraps to (0,0) and raises frame_start.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_x           <= H_LAST;
      r_y           <= V_LAST;
      r_hsync       <= sync_level(1'b0, H_POL);
      r_vsync       <= sync_level(1'b0, V_POL);
      r_video_on    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= 8'd0;
    end else if (w_p_tick) begin
      r_x           <= w_x_next;
      r_y           <= w_y_next;
      r_hsync       <= sync_level(w_hs_active_next, H_POL);
      r_vsync       <= sync_level(w_vs_active_next, V_POL);
      r_video_on    <= w_video_next;
      r_line_start  <= w_line_next;
      r_frame_start <= w_frame_next;
      if (w_frame_next) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end else begin
      // Strobes last exactly one clock: cleared on any edge without a pixel
      // strobe, which also covers the enable-low case. Everything else holds.
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign o_p_tick      = w_p_tick;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_video_on    = r_video_on;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two instances on a small raster (15 x 6, 90 pixels per frame):
//     u0: CLK_DIV=3, active-low syncs
//     u1: CLK_DIV=1, active-high syncs (runs past 256 frames for the wrap)
//   Each has its own randomized enable; both share the reset, which is
//   pulsed at start-up and twice mid-frame.
//   The reference model only counts enabled clocks and pixel ticks since
//   reset and derives every output from those counts arithmetically.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int HD = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int HT = HD + HF + HS + HB;
  localparam int VD = 3;
  localparam int VF = 1;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VT = VD + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int CW = 4;
  localparam int NCYC = 32000;
  localparam int MAX_ERR = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en0;
  logic en1;

  logic          pt0, hs0, vs0, vo0, ls0, fs0;
  logic [CW-1:0] x0, y0;
  logic [7:0]    fc0;
  logic          pt1, hs1, vs1, vo1, ls1, fs1;
  logic [CW-1:0] x1, y1;
  logic [7:0]    fc1;

  vga_timing_gen #(
    .CLK_DIV(3), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_POL(1'b0), .V_POL(1'b0), .CW(CW)
  ) u0 (
    .i_clk(clk), .i_reset(rst_n), .i_en(en0), .o_p_tick(pt0),
    .o_hsync(hs0), .o_vsync(vs0), .o_video_on(vo0), .o_line_start(ls0),
    .o_frame_start(fs0), .o_x(x0), .o_y(y0), .o_frame_cnt(fc0)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_POL(1'b1), .V_POL(1'b1), .CW(CW)
  ) u1 (
    .i_clk(clk), .i_reset(rst_n), .i_en(en1), .o_p_tick(pt1),
    .o_hsync(hs1), .o_vsync(vs1), .o_video_on(vo1), .o_line_start(ls1),
    .o_frame_start(fs1), .o_x(x1), .o_y(y1), .o_frame_cnt(fc1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_div[2] = '{3, 1};
  bit m_pol[2] = '{1'b0, 1'b1};
  int m_clks[2];   // enabled clock edges since reset
  int m_ticks[2];  // pixel ticks since reset
  bit m_last[2];   // a pixel tick happened on the most recent edge

  task automatic model_reset(input int k);
    m_clks[k]  = 0;
    m_ticks[k] = 0;
    m_last[k]  = 1'b0;
  endtask

  function automatic bit model_tick(input int k, input logic en_v);
    return en_v && ((m_clks[k] % m_div[k]) == m_div[k] - 1);
  endfunction

  task automatic model_step(input int k, input logic en_v);
    bit t;
    t = model_tick(k, en_v);
    if (en_v) m_clks[k]++;
    if (t) m_ticks[k]++;
    m_last[k] = t;
  endtask

  task automatic check_inst(input int k, input logic en_v,
                            input logic pt, input logic hs, input logic vs,
                            input logic vo, input logic ls, input logic fs,
                            input logic [CW-1:0] x, input logic [CW-1:0] y,
                            input logic [7:0] fc);
    int  lin, ex, ey, efc;
    bit  hact, vact, evo, ept;
    // Raster index: reset sits one pixel before (0,0).
    lin  = (m_ticks[k] + FR - 1) % FR;
    ex   = lin % HT;
    ey   = lin / HT;
    hact = (ex >= HD + HF) && (ex < HD + HF + HS);
    vact = (ey >= VD + VF) && (ey < VD + VF + VS);
    evo  = (ex < HD) && (ey < VD);
    ept  = rst_n && model_tick(k, en_v);
    efc  = ((m_ticks[k] + FR - 1) / FR) % 256;
    check_eq($sformatf("u%0d.p_tick", k), pt, ept);
    check_eq($sformatf("u%0d.x", k), x, ex);
    check_eq($sformatf("u%0d.y", k), y, ey);
    check_eq($sformatf("u%0d.hsync", k), hs, hact ? m_pol[k] : !m_pol[k]);
    check_eq($sformatf("u%0d.vsync", k), vs, vact ? m_pol[k] : !m_pol[k]);
    check_eq($sformatf("u%0d.video_on", k), vo, evo);
    check_eq($sformatf("u%0d.line_start", k), ls, m_last[k] && ex == 0);
    check_eq($sformatf("u%0d.frame_start", k), fs, m_last[k] && lin == 0);
    check_eq($sformatf("u%0d.frame_cnt", k), fc, efc);
  endtask

  // ---------------- stimulus ----------------
  int burst0 = 0;
  int rst2_at;

  task automatic drive_en();
    if (burst0 > 0) begin
      en0 = 1'b0;
      burst0--;
    end else if ($urandom_range(0, 63) == 0) begin
      burst0 = $urandom_range(5, 30);
      en0 = 1'b0;
    end else begin
      en0 = ($urandom_range(0, 9) != 0);
    end
    en1 = ($urandom_range(0, 19) != 0);
  endtask

  initial begin
    rst_n = 1'b0;
    en0   = 1'b0;
    en1   = 1'b0;
    model_reset(0);
    model_reset(1);
    rst2_at = $urandom_range(1500, 2500);
    for (int cyc = 0; cyc < NCYC && n_errors < MAX_ERR; cyc++) begin
      @(negedge clk);
      if (cyc < 4 || (cyc >= 700 && cyc < 702) || (cyc >= rst2_at && cyc < rst2_at + 3)) begin
        rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
      end else begin
        rst_n = 1'b1;
      end
      drive_en();
      #1;
      check_inst(0, en0, pt0, hs0, vs0, vo0, ls0, fs0, x0, y0, fc0);
      check_inst(1, en1, pt1, hs1, vs1, vo1, ls1, fs1, x1, y1, fc1);
      @(posedge clk);
      if (rst_n) begin
        model_step(0, en0);
        model_step(1, en1);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
